// File: rtl/fpu_share_arbiter_if.sv
// Signal bundle between the cluster cores' APU ports, the shared FPU port and fpu_share_arbiter.
// slave is the arbiter's view; master is the surrounding cores + FPU wrapper.
interface fpu_share_arbiter_if #(
   parameter int NB_CORES        = 4,
   parameter int NB_ARGS         = 3,
   parameter int DATA_WIDTH      = 32,
   parameter int OPCODE_WIDTH    = 6,
   parameter int FLAGS_IN_WIDTH  = 15,
   parameter int FLAGS_OUT_WIDTH = 5,
   parameter int ID_WIDTH        = 9
);
   logic [NB_CORES-1:0]                             core_req_i;
   logic [NB_CORES-1:0]                             core_gnt_o;
   logic [NB_CORES-1:0][NB_ARGS-1:0][DATA_WIDTH-1:0] core_operands_i;
   logic [NB_CORES-1:0][OPCODE_WIDTH-1:0]           core_op_i;
   logic [NB_CORES-1:0][FLAGS_IN_WIDTH-1:0]         core_flags_i;
   logic [NB_CORES-1:0]                             core_rvalid_o;
   logic [DATA_WIDTH-1:0]                           core_rdata_o;
   logic [FLAGS_OUT_WIDTH-1:0]                      core_rflags_o;

   logic                                            fpu_req_o;
   logic                                            fpu_gnt_i;
   logic [ID_WIDTH-1:0]                             fpu_ID_o;
   logic [NB_ARGS-1:0][DATA_WIDTH-1:0]              fpu_operands_o;
   logic [OPCODE_WIDTH-1:0]                         fpu_op_o;
   logic [FLAGS_IN_WIDTH-1:0]                       fpu_flags_o;
   logic                                            fpu_rvalid_i;
   logic [DATA_WIDTH-1:0]                           fpu_rdata_i;
   logic [FLAGS_OUT_WIDTH-1:0]                      fpu_rflags_i;
   logic [ID_WIDTH-1:0]                             fpu_rID_i;

   logic                                            err_o;

   modport slave (
      input  core_req_i, core_operands_i, core_op_i, core_flags_i,
             fpu_gnt_i, fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i, fpu_rID_i,
      output core_gnt_o, core_rvalid_o, core_rdata_o, core_rflags_o,
             fpu_req_o, fpu_ID_o, fpu_operands_o, fpu_op_o, fpu_flags_o, err_o
   );

   modport master (
      output core_req_i, core_operands_i, core_op_i, core_flags_i,
             fpu_gnt_i, fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i, fpu_rID_i,
      input  core_gnt_o, core_rvalid_o, core_rdata_o, core_rflags_o,
             fpu_req_o, fpu_ID_o, fpu_operands_o, fpu_op_o, fpu_flags_o, err_o
   );
endinterface

// File: rtl/fpu_share_arbiter.sv
// Round-robin sharing of one FPU port among NB_CORES cores, with per-core credit
// counters and a one-cycle registered response router back to the cores.
module fpu_share_arbiter #(
   parameter int NB_CORES        = 4,
   parameter int NB_ARGS         = 3,
   parameter int DATA_WIDTH      = 32,
   parameter int OPCODE_WIDTH    = 6,
   parameter int FLAGS_IN_WIDTH  = 15,
   parameter int FLAGS_OUT_WIDTH = 5,
   parameter int ID_WIDTH        = 9,
   parameter int MAX_OUTSTANDING = 4
) (
   input logic                clk,
   input logic                rst,
   fpu_share_arbiter_if.slave bus
);
   localparam int IDX_W = $clog2(NB_CORES);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic {ST_IDLE, ST_HOLD} state_t;

   state_t                         r_state;
   state_t                         w_state_next;
   logic [IDX_W-1:0]               r_rr_ptr;
   logic [IDX_W-1:0]               r_hold_idx;
   logic [NB_CORES-1:0][CNT_W-1:0] r_cnt;
   logic [NB_CORES-1:0]            r_rvalid;
   logic [DATA_WIDTH-1:0]          r_rdata;
   logic [FLAGS_OUT_WIDTH-1:0]     r_rflags;
   logic                           r_err;

   logic [NB_CORES-1:0]            w_elig;
   logic [NB_CORES-1:0]            w_inc;
   logic [NB_CORES-1:0]            w_dec;
   logic [IDX_W-1:0]               w_rr_win;
   logic [IDX_W-1:0]               w_win;
   logic [IDX_W-1:0]               w_sel;
   logic [IDX_W-1:0]               w_rsp_idx;
   logic                           w_any;
   logic                           w_req;
   logic                           w_hs;
   logic                           w_hold_drop;
   logic                           w_rid_ok;
   logic                           w_underflow;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      int j;
      w_elig   = '0;
      w_any    = 1'b0;
      w_rr_win = '0;
      for (int i = 0; i < NB_CORES; i++)
         w_elig[i] = bus.core_req_i[i] && (r_cnt[i] < CNT_W'(MAX_OUTSTANDING));
      for (int k = 0; k < NB_CORES; k++) begin
         j = int'(r_rr_ptr) + k;
         if (j >= NB_CORES) j = j - NB_CORES;
         if (!w_any && w_elig[j]) begin
            w_any    = 1'b1;
            w_rr_win = IDX_W'(j);
         end
      end
   end

   // HOLD freezes the stalled winner so its payload stays stable until the FPU accepts it.
   always_comb begin
      w_state_next = r_state;
      w_req        = 1'b0;
      w_win        = w_rr_win;
      w_hold_drop  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_req = w_any;
            if (w_any && !bus.fpu_gnt_i) w_state_next = ST_HOLD;
         end
         ST_HOLD: begin
            w_win = r_hold_idx;
            if (!bus.core_req_i[r_hold_idx]) begin
               w_hold_drop  = 1'b1;
               w_state_next = ST_IDLE;
            end else begin
               w_req = 1'b1;
               if (bus.fpu_gnt_i) w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign w_hs      = w_req & bus.fpu_gnt_i;
   assign w_sel     = w_req ? w_win : '0;
   assign w_rsp_idx = IDX_W'(bus.fpu_rID_i);
   assign w_rid_ok  = 32'(bus.fpu_rID_i) < 32'(NB_CORES);

   always_comb begin
      w_inc       = '0;
      w_dec       = '0;
      w_underflow = 1'b0;
      for (int i = 0; i < NB_CORES; i++) begin
         w_inc[i] = w_hs && (w_win == IDX_W'(i));
         w_dec[i] = bus.fpu_rvalid_i && w_rid_ok && (w_rsp_idx == IDX_W'(i));
         if (w_dec[i] && !w_inc[i] && (r_cnt[i] == '0)) w_underflow = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_hold_idx <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == ST_IDLE) r_hold_idx <= w_rr_win;
      end
   end

   // NOTE: the credit counters are all reset, otherwise cores could start with phantom in-flight credits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr <= '0;
         r_cnt    <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_hs) r_rr_ptr <= (w_win == IDX_W'(NB_CORES - 1)) ? '0 : w_win + 1'b1;
         for (int i = 0; i < NB_CORES; i++) begin
            if (w_inc[i] && !w_dec[i])
               r_cnt[i] <= r_cnt[i] + 1'b1;
            else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0))
               r_cnt[i] <= r_cnt[i] - 1'b1;
         end
         r_err <= r_err | w_hold_drop | (bus.fpu_rvalid_i & ~w_rid_ok) | w_underflow;
      end
   end

   // Responses cannot be back-pressured, so they are simply registered and steered by tag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rvalid <= '0;
         r_rdata  <= '0;
         r_rflags <= '0;
      end else begin
         r_rvalid <= w_dec;
         if (bus.fpu_rvalid_i) begin
            r_rdata  <= bus.fpu_rdata_i;
            r_rflags <= bus.fpu_rflags_i;
         end
      end
   end

   assign bus.fpu_req_o      = w_req;
   assign bus.core_gnt_o     = w_inc;
   assign bus.fpu_ID_o       = ID_WIDTH'(w_sel);
   assign bus.fpu_operands_o = bus.core_operands_i[w_sel];
   assign bus.fpu_op_o       = bus.core_op_i[w_sel];
   assign bus.fpu_flags_o    = bus.core_flags_i[w_sel];
   assign bus.core_rvalid_o  = r_rvalid;
   assign bus.core_rdata_o   = r_rdata;
   assign bus.core_rflags_o  = r_rflags;
   assign bus.err_o          = r_err;
endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Bench for fpu_share_arbiter: arbitration vector table, response scoreboard,
// and hand-written sequences for HOLD, credit limit and error corners.
module tb_fpu_share_arbiter;
   localparam int NB_CORES        = 4;
   localparam int NB_ARGS         = 3;
   localparam int DATA_WIDTH      = 32;
   localparam int OPCODE_WIDTH    = 6;
   localparam int FLAGS_IN_WIDTH  = 15;
   localparam int FLAGS_OUT_WIDTH = 5;
   localparam int ID_WIDTH        = 9;
   localparam int MAX_OUTSTANDING = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fpu_share_arbiter_if #(
      .NB_CORES(NB_CORES), .NB_ARGS(NB_ARGS), .DATA_WIDTH(DATA_WIDTH),
      .OPCODE_WIDTH(OPCODE_WIDTH), .FLAGS_IN_WIDTH(FLAGS_IN_WIDTH),
      .FLAGS_OUT_WIDTH(FLAGS_OUT_WIDTH), .ID_WIDTH(ID_WIDTH)
   ) bus ();

   fpu_share_arbiter #(
      .NB_CORES(NB_CORES), .NB_ARGS(NB_ARGS), .DATA_WIDTH(DATA_WIDTH),
      .OPCODE_WIDTH(OPCODE_WIDTH), .FLAGS_IN_WIDTH(FLAGS_IN_WIDTH),
      .FLAGS_OUT_WIDTH(FLAGS_OUT_WIDTH), .ID_WIDTH(ID_WIDTH),
      .MAX_OUTSTANDING(MAX_OUTSTANDING)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   typedef struct {
      logic [3:0]  rvalid;
      logic [31:0] data;
      logic [4:0]  flags;
   } rsp_t;

   typedef struct {
      logic [3:0]  req;
      logic        gnt;
      logic        rsp_v;
      logic [8:0]  rsp_id;
      logic [31:0] rsp_data;
      logic        exp_req;
      logic [3:0]  exp_gnt;
      int          exp_core;
   } vec_t;

   rsp_t rsp_q[$];
   vec_t vq[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] opnd(input int c, input int a);
      return 32'hC000_0000 | 32'(c << 8) | 32'(a);
   endfunction
   function automatic logic [5:0] op_of(input int c);
      return 6'(2 * c + 1);
   endfunction
   function automatic logic [14:0] flags_of(input int c);
      return 15'(256 + c);
   endfunction

   task automatic drive(input logic [3:0] req, input logic gnt);
      bus.core_req_i   = req;
      bus.fpu_gnt_i    = gnt;
      bus.fpu_rvalid_i = 1'b0;
      bus.fpu_rID_i    = '0;
      bus.fpu_rdata_i  = '0;
      bus.fpu_rflags_i = '0;
   endtask

   // Drives an FPU response this cycle and queues what the cores must see one cycle later.
   task automatic drive_rsp(input logic [8:0] id, input logic [31:0] data, input logic [4:0] flags);
      rsp_t e;
      bus.fpu_rvalid_i = 1'b1;
      bus.fpu_rID_i    = id;
      bus.fpu_rdata_i  = data;
      bus.fpu_rflags_i = flags;
      e.rvalid = (id < 9'd4) ? 4'(1 << id) : 4'b0;
      e.data   = data;
      e.flags  = flags;
      rsp_q.push_back(e);
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic tick();
      rsp_t e;
      @(posedge clk);
      #1;
      if (rsp_q.size() != 0) begin
         e = rsp_q.pop_front();
         check("rsp.rvalid", bus.core_rvalid_o, e.rvalid);
         check("rsp.rdata", bus.core_rdata_o, e.data);
         check("rsp.rflags", bus.core_rflags_o, e.flags);
      end else begin
         check("rvalid_idle", bus.core_rvalid_o, 4'b0);
      end
   endtask

   task automatic chk_req(input string tag, input logic exp_req, input logic [3:0] exp_gnt,
                          input int exp_core);
      int c;
      c = exp_req ? exp_core : 0;
      check({tag, ".req"}, bus.fpu_req_o, exp_req);
      check({tag, ".gnt"}, bus.core_gnt_o, exp_gnt);
      check({tag, ".id"}, bus.fpu_ID_o, 64'(c));
      check({tag, ".op"}, bus.fpu_op_o, op_of(c));
      check({tag, ".flags"}, bus.fpu_flags_o, flags_of(c));
      check({tag, ".opnd0"}, bus.fpu_operands_o[0], opnd(c, 0));
      check({tag, ".opnd2"}, bus.fpu_operands_o[2], opnd(c, 2));
   endtask

   task automatic do_reset();
      drive(4'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      rsp_q.delete();
   endtask

   task automatic add_vec(input logic [3:0] req, input logic gnt, input logic rsp_v,
                          input logic [8:0] rsp_id, input logic exp_req,
                          input logic [3:0] exp_gnt, input int exp_core);
      vec_t v;
      v.req = req;  v.gnt = gnt;  v.rsp_v = rsp_v;  v.rsp_id = rsp_id;
      v.rsp_data = 32'hA500_0000 | 32'(vq.size());
      v.exp_req = exp_req;  v.exp_gnt = exp_gnt;  v.exp_core = exp_core;
      vq.push_back(v);
   endtask

   initial begin
      for (int c = 0; c < NB_CORES; c++) begin
         for (int a = 0; a < NB_ARGS; a++) bus.core_operands_i[c][a] = opnd(c, a);
         bus.core_op_i[c]    = op_of(c);
         bus.core_flags_i[c] = flags_of(c);
      end
      do_reset();

      check("rst.rvalid", bus.core_rvalid_o, 4'b0);
      check("rst.rdata", bus.core_rdata_o, 32'h0);
      check("rst.rflags", bus.core_rflags_o, 5'h0);
      check("rst.err", bus.err_o, 1'b0);
      check("rst.fpu_req", bus.fpu_req_o, 1'b0);
      check("rst.rr_ptr", dut.r_rr_ptr, 2'd0);
      check("rst.cnt", dut.r_cnt, 12'h0);
      check("rst.state", dut.r_state, 1'b0);

      // Fairness: all cores request, FPU always ready; then mixed traffic with responses.
      for (int n = 0; n < 8; n++) add_vec(4'hF, 1'b1, 1'b0, 9'd0, 1'b1, 4'(1 << (n % 4)), n % 4);
      add_vec(4'b1010, 1'b1, 1'b1, 9'd0, 1'b1, 4'b0010, 1);
      add_vec(4'b1010, 1'b1, 1'b1, 9'd1, 1'b1, 4'b1000, 3);
      add_vec(4'b1010, 1'b1, 1'b1, 9'd3, 1'b1, 4'b0010, 1);
      add_vec(4'b0001, 1'b1, 1'b1, 9'd2, 1'b1, 4'b0001, 0);
      add_vec(4'b0000, 1'b0, 1'b1, 9'd0, 1'b0, 4'b0000, 0);

      for (int r = 0; r < vq.size(); r++) begin
         drive(vq[r].req, vq[r].gnt);
         if (vq[r].rsp_v) drive_rsp(vq[r].rsp_id, vq[r].rsp_data, 5'(r));
         settle();
         chk_req($sformatf("vec%0d", r), vq[r].exp_req, vq[r].exp_gnt, vq[r].exp_core);
         tick();
      end
      check("vec.cnt0", dut.r_cnt[0], 3'd1);
      check("vec.cnt1", dut.r_cnt[1], 3'd3);
      check("vec.cnt2", dut.r_cnt[2], 3'd1);
      check("vec.cnt3", dut.r_cnt[3], 3'd2);
      check("vec.err", bus.err_o, 1'b0);

      // Single request with same-cycle grant, then its response.
      do_reset();
      drive(4'b0100, 1'b1);
      settle();
      chk_req("single", 1'b1, 4'b0100, 2);
      tick();
      check("single.cnt_up", dut.r_cnt[2], 3'd1);
      drive(4'b0, 1'b0);
      drive_rsp(9'd2, 32'h3F80_0000, 5'h03);
      settle();
      tick();
      check("single.cnt_down", dut.r_cnt[2], 3'd0);
      drive(4'b0, 1'b0);
      settle();
      tick();

      // Stall: winner held even when a higher-priority core joins.
      do_reset();
      drive(4'b1010, 1'b0);  settle();  chk_req("hold0", 1'b1, 4'b0000, 1);  tick();
      drive(4'b1011, 1'b0);  settle();  chk_req("hold1", 1'b1, 4'b0000, 1);  tick();
      drive(4'b1011, 1'b0);  settle();  chk_req("hold2", 1'b1, 4'b0000, 1);  tick();
      drive(4'b1010, 1'b1);  settle();  chk_req("hold_gnt", 1'b1, 4'b0010, 1);  tick();
      drive(4'b1010, 1'b1);  settle();  chk_req("hold_next", 1'b1, 4'b1000, 3);  tick();
      check("hold.err", bus.err_o, 1'b0);

      // Credit limit on core 0.
      do_reset();
      for (int n = 0; n < MAX_OUTSTANDING; n++) begin
         drive(4'b0001, 1'b1);
         settle();
         chk_req($sformatf("credit%0d", n), 1'b1, 4'b0001, 0);
         tick();
      end
      drive(4'b0001, 1'b1);  settle();  chk_req("credit_full", 1'b0, 4'b0000, 0);  tick();
      drive(4'b0001, 1'b1);
      drive_rsp(9'd0, 32'h1234_5678, 5'h1F);
      settle();
      chk_req("credit_rsp", 1'b0, 4'b0000, 0);
      tick();
      drive(4'b0001, 1'b1);  settle();  chk_req("credit_again", 1'b1, 4'b0001, 0);  tick();
      check("credit.cnt0", dut.r_cnt[0], 3'd4);

      // Grant and response for the same core in one cycle.
      do_reset();
      drive(4'b0010, 1'b1);  settle();  chk_req("simul0", 1'b1, 4'b0010, 1);  tick();
      drive(4'b0010, 1'b1);  settle();  chk_req("simul1", 1'b1, 4'b0010, 1);  tick();
      drive(4'b0010, 1'b1);
      drive_rsp(9'd1, 32'hCAFE_F00D, 5'h0A);
      settle();
      chk_req("simul2", 1'b1, 4'b0010, 1);
      tick();
      check("simul.cnt1", dut.r_cnt[1], 3'd2);
      check("simul.err", bus.err_o, 1'b0);

      // Out-of-range tag.
      do_reset();
      drive(4'b0, 1'b0);
      drive_rsp(9'd7, 32'h0BAD_0007, 5'h07);
      settle();
      tick();
      check("bad_id.err", bus.err_o, 1'b1);
      check("bad_id.cnt", dut.r_cnt, 12'h0);

      // Response with no outstanding request.
      do_reset();
      check("err_cleared", bus.err_o, 1'b0);
      drive(4'b0, 1'b0);
      drive_rsp(9'd3, 32'h5555_AAAA, 5'h15);
      settle();
      tick();
      check("underflow.err", bus.err_o, 1'b1);
      check("underflow.cnt3", dut.r_cnt[3], 3'd0);

      // Held core withdraws its request.
      do_reset();
      drive(4'b0100, 1'b0);  settle();  chk_req("drop0", 1'b1, 4'b0000, 2);  tick();
      check("drop0.err", bus.err_o, 1'b0);
      drive(4'b0000, 1'b0);  settle();
      check("drop.req", bus.fpu_req_o, 1'b0);
      check("drop.gnt", bus.core_gnt_o, 4'b0);
      tick();
      check("drop.err", bus.err_o, 1'b1);
      drive(4'b0010, 1'b1);  settle();  chk_req("drop_after", 1'b1, 4'b0010, 1);  tick();

      // Asynchronous reset while in HOLD, followed by a late response.
      do_reset();
      drive(4'b0010, 1'b1);  settle();  chk_req("mid0", 1'b1, 4'b0010, 1);  tick();
      drive(4'b1010, 1'b0);
      drive_rsp(9'd1, 32'hDEAD_BEEF, 5'h11);
      settle();
      chk_req("mid1", 1'b1, 4'b0000, 3);
      tick();
      drive(4'b1010, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst.rvalid", bus.core_rvalid_o, 4'b0);
      check("mid_rst.rdata", bus.core_rdata_o, 32'h0);
      check("mid_rst.rflags", bus.core_rflags_o, 5'h0);
      check("mid_rst.cnt", dut.r_cnt, 12'h0);
      check("mid_rst.state", dut.r_state, 1'b0);
      check("mid_rst.id", bus.fpu_ID_o, 9'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(4'b0, 1'b0);
      drive_rsp(9'd1, 32'h7777_0001, 5'h02);
      settle();
      tick();
      check("late.err", bus.err_o, 1'b1);
      check("late.cnt1", dut.r_cnt[1], 3'd0);

      check("scoreboard_empty", 64'(rsp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
